// File: rtl/seq_sub_pkg.sv
// seq_sub_pkg: shared types and defaults for the sequential sliced subtractor
package seq_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 8;
    localparam int IDX_W_DEF = $clog2(WIDTH_DEF / SLICE_DEF);
    // Single-slice configurations still need a 1-bit index register.
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_sub_slice_if.sv
// seq_sub_slice_if: start/done request and result bundle for seq_sub_slice
interface seq_sub_slice_if
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;
    modport master (output start, a, b, bin, input busy, done, diff, bout, zero, neg, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, neg, ovf);
endinterface

// File: rtl/sub_slice_cla.sv
// sub_slice_cla: combinational SLICE-bit carry-lookahead adder (x + y + cin)
module sub_slice_cla #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    assign g = x & y;
    assign p = x ^ y;
    // Each carry is a flat sum of generate terms gated by the propagates above them.
    always_comb begin
        logic acc;
        logic t;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            acc = cin;
            for (int j = 0; j <= i; j++) acc = acc & p[j];
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                acc = acc | t;
            end
            c[i+1] = acc;
        end
    end
    assign s    = p ^ c[SLICE-1:0];
    assign cout = c[SLICE];
endmodule

// File: rtl/seq_sub_slice.sv
// seq_sub_slice: multi-cycle a - b - bin, SLICE bits per clock; SEQ_SUB_FLAGS_EN adds zero/neg/ovf flags
module seq_sub_slice
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    seq_sub_slice_if.slave io
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = idx_w(N);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] nb_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_nx;
    logic             cy;
    logic             busy_r;
    logic             done_r;
    logic             bout_r;
    logic [SLICE-1:0] s;
    logic             co;
    logic             last;
    int               base;

    assign base = int'(idx) * SLICE;
    assign last = idx == IW'(N - 1);

    sub_slice_cla #(.SLICE(SLICE)) u_cla (
        .x    (a_r[base +: SLICE]),
        .y    (nb_r[base +: SLICE]),
        .cin  (cy),
        .s    (s),
        .cout (co)
    );

    always_comb begin
        diff_nx = diff_r;
        diff_nx[base +: SLICE] = s;
    end

    // Subtraction is a + ~b + ~bin; the final carry inverted is the borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            a_r    <= '0;
            nb_r   <= '0;
            cy     <= 1'b0;
            diff_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == RUN) begin
                diff_r <= diff_nx;
                cy     <= co;
                idx    <= last ? '0 : idx + 1'b1;
                if (last) begin
                    state  <= DONE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    bout_r <= ~co;
                end
            end else if (io.start) begin
                a_r    <= io.a;
                nb_r   <= ~io.b;
                cy     <= ~io.bin;
                idx    <= '0;
                busy_r <= 1'b1;
                state  <= RUN;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign io.busy = busy_r;
    assign io.done = done_r;
    assign io.diff = diff_r;
    assign io.bout = bout_r;

`ifdef SEQ_SUB_FLAGS_EN
    logic zero_r;
    logic neg_r;
    logic ovf_r;
    // nb_r holds ~b, so equal operand signs means a and b differ in sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (state == RUN && last) begin
            zero_r <= diff_nx == '0;
            neg_r  <= diff_nx[WIDTH-1];
            ovf_r  <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) && (diff_nx[WIDTH-1] != a_r[WIDTH-1]);
        end
    end
    assign io.zero = zero_r;
    assign io.neg  = neg_r;
    assign io.ovf  = ovf_r;
`else
    assign io.zero = 1'b0;
    assign io.neg  = 1'b0;
    assign io.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_seq_sub_slice.sv
// tb_seq_sub_slice: randomized and directed checks of seq_sub_slice against an arithmetic model
module tb_seq_sub_slice;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    seq_sub_slice_if #(.WIDTH(32)) io ();

    seq_sub_slice #(.WIDTH(32), .SLICE(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        logic z, n, o;
        r = {1'b0, a} - {1'b0, b} - {32'd0, bin};
`ifdef SEQ_SUB_FLAGS_EN
        z = r[31:0] == 32'd0;
        n = r[31];
        o = (a[31] != b[31]) && (r[31] != a[31]);
`else
        z = 1'b0;
        n = 1'b0;
        o = 1'b0;
`endif
        return {o, n, z, r[32], r[31:0]};
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                         output logic [35:0] obs, output logic obusy, output int lat);
        @(negedge clk);
        io.start = 1'b1;
        io.a = ta;
        io.b = tb;
        io.bin = tbin;
        @(negedge clk);
        io.start = 1'b0;
        io.a = $urandom;
        io.b = $urandom;
        io.bin = 1'b0;
        obusy = io.busy;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!io.done && lat < 20);
        obs = {io.ovf, io.neg, io.zero, io.bout, io.diff};
    endtask

    task automatic test_reset;
        io.start = 1'b0;
        io.a = '0;
        io.b = '0;
        io.bin = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({io.busy, io.done, io.bout, io.zero, io.neg, io.ovf} !== 6'b0 || io.diff !== 32'd0) begin
            errors++;
            $display("FAIL reset_state busy/done/bout/z/n/o=%b diff=%h required all zero", {io.busy, io.done, io.bout, io.zero, io.neg, io.ovf}, io.diff);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [6] = '{32'h5, 32'h10000, 32'h0, 32'h80000000, 32'h12345678, 32'h12345678};
        logic [31:0] tb [6] = '{32'h3, 32'h1, 32'h1, 32'h1, 32'h12345678, 32'h12345678};
        logic        tbi [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ed [6] = '{32'h2, 32'hFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF};
        logic        eb [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [35:0] obs, exp;
        logic bsy;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], tbi[i], obs, bsy, lat);
            exp = model(ta[i], tb[i], tbi[i]);
            checks++;
            if (obs[31:0] !== ed[i] || obs[32] !== eb[i]) begin
                errors++;
                $display("FAIL directed_%0d diff=%h bout=%b required diff=%h bout=%b", i, obs[31:0], obs[32], ed[i], eb[i]);
            end
            checks++;
            if (obs[35:33] !== exp[35:33]) begin
                errors++;
                $display("FAIL directed_flags_%0d ovf/neg/zero=%b required %b", i, obs[35:33], exp[35:33]);
            end
            checks++;
            if (lat !== 4 || bsy !== 1'b1) begin
                errors++;
                $display("FAIL directed_latency_%0d lat=%0d busy=%b required lat=4 busy=1", i, lat, bsy);
            end
            @(negedge clk);
            checks++;
            if (io.done !== 1'b0 || io.diff !== ed[i]) begin
                errors++;
                $display("FAIL directed_hold_%0d done=%b diff=%h required done=0 diff=%h", i, io.done, io.diff, ed[i]);
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [35:0] exp;
        logic [31:0] got;
        int ndone = 0;
        exp = model(32'hDEADBEEF, 32'h01234567, 1'b1);
        got = '0;
        @(negedge clk);
        io.start = 1'b1; io.a = 32'hDEADBEEF; io.b = 32'h01234567; io.bin = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        @(negedge clk);
        io.start = 1'b1; io.a = 32'h11111111; io.b = 32'h22222222; io.bin = 1'b0;
        @(negedge clk);
        io.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (io.done) begin
                ndone++;
                got = io.diff;
            end
        end
        checks++;
        if (ndone !== 1 || got !== exp[31:0]) begin
            errors++;
            $display("FAIL busy_ignore dones=%0d diff=%h required dones=1 diff=%h", ndone, got, exp[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [35:0] e1, e2;
        int lat = 0;
        e1 = model(32'h00000100, 32'h00000001, 1'b0);
        e2 = model(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        io.start = 1'b1; io.a = 32'h00000100; io.b = 32'h00000001; io.bin = 1'b0;
        @(negedge clk);
        io.start = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!io.done && lat < 20);
        checks++;
        if (io.diff !== e1[31:0] || io.bout !== e1[32] || lat !== 4) begin
            errors++;
            $display("FAIL b2b_first diff=%h bout=%b lat=%0d required diff=%h bout=%b lat=4", io.diff, io.bout, lat, e1[31:0], e1[32]);
        end
        io.start = 1'b1; io.a = 32'h7FFFFFFF; io.b = 32'hFFFFFFFF; io.bin = 1'b0;
        @(negedge clk);
        io.start = 1'b0;
        checks++;
        if (io.busy !== 1'b1 || io.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b done=%b required busy=1 done=0", io.busy, io.done);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!io.done && lat < 20);
        checks++;
        if (io.diff !== e2[31:0] || io.bout !== e2[32] || {io.ovf, io.neg, io.zero} !== e2[35:33] || lat !== 4) begin
            errors++;
            $display("FAIL b2b_second diff=%h bout=%b flags=%b lat=%0d required diff=%h bout=%b flags=%b lat=4", io.diff, io.bout, {io.ovf, io.neg, io.zero}, lat, e2[31:0], e2[32], e2[35:33]);
        end
    endtask

    task automatic test_async_reset;
        logic [35:0] obs, exp;
        logic bsy;
        int lat;
        int ndone = 0;
        @(negedge clk);
        io.start = 1'b1; io.a = 32'hFFFF0000; io.b = 32'h0000FFFF; io.bin = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({io.busy, io.done, io.bout} !== 3'b0 || io.diff !== 32'd0) begin
            errors++;
            $display("FAIL async_reset busy/done/bout=%b diff=%h required 000 diff=0", {io.busy, io.done, io.bout}, io.diff);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (io.done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL async_reset_no_done dones=%0d required 0", ndone);
        end
        exp = model(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
        do_op(32'hCAFEF00D, 32'h0BADBEEF, 1'b0, obs, bsy, lat);
        checks++;
        if (obs !== exp || lat !== 4) begin
            errors++;
            $display("FAIL async_reset_recover obs=%h lat=%0d required %h lat=4", obs, lat, exp);
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb;
        logic rbin, bsy;
        logic [35:0] obs, exp;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            if (i % 8 == 3) rb = {~ra[31], rb[30:0]};
            rbin = 1'($urandom_range(0, 1));
            exp = model(ra, rb, rbin);
            do_op(ra, rb, rbin, obs, bsy, lat);
            checks++;
            if (obs !== exp || lat !== 4) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h bin=%b obs=%h lat=%0d required %h lat=4", i, ra, rb, rbin, obs, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_sub_slice.md
Name: seq_sub_slice

Overview:
- Multi-cycle, multi-precision subtractor: computes diff = a - b - bin on WIDTH-bit operands, SLICE bits per clock, with the borrow chained between slices.
- It is the inverse-direction companion to the team's CLA adders and reuses a SLICE-bit lookahead adder as its datapath.
- Sits beside the register bank for the SUB/CMP paths.
- Uses a start/done handshake, so narrow adder hardware serves wide operands.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; N = WIDTH/SLICE cycles per operation.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff/bout are valid.
- diff  output  WIDTH  result a - b - bin (mod 2^WIDTH).
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
- zero  output  1  flag, see Optional Feature.
- neg  output  1  flag, see Optional Feature.
- ovf  output  1  flag, see Optional Feature.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, slice index=0, busy=0, done=0, diff=0, bout=0, zero=0, neg=0, ovf=0. Any operation in progress is aborted with no done pulse.
- FSM states:
  - IDLE: start=1 at edge k -> latch a, ~b, carry=~bin; index=0; busy=1; go to RUN.
  - RUN: each edge computes slice[index] = a_s + ~b_s + carry via the sub-module, writes that slice of diff, stores the slice carry-out, and increments index. On the edge where index=N-1: go to DONE, busy=0, done=1, bout = ~final carry.
  - DONE: lasts one cycle, then done=0. The state is start-accepting: start=1 here is accepted exactly as in IDLE. Otherwise go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+N (N=4 at defaults).
- start while busy=1 is ignored; the latched operands are unaffected.
- diff and bout hold their last result until the next accepted start. diff is not guaranteed stable while busy=1.
- Arithmetic: all unsigned modulo 2^WIDTH. The carry into slice 0 is ~bin. Slice carries are never dropped.
- ovf is signed two's-complement overflow: sign(a) != sign(b) and sign(diff) != sign(a).

Optional Feature:
- Macro SEQ_SUB_FLAGS_EN.
- Defined: zero = (diff==0), neg = diff[WIDTH-1], ovf as defined above. All three are registered on the same edge as done and held with diff.
- Undefined: zero, neg and ovf are tied to 0, and no flag logic is synthesized. Ports remain present so the interface is identical in both builds.

Decomposition:
- Shared package seq_sub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - defaults WIDTH_DEF=32, SLICE_DEF=8;
  - index width localparam derived as $clog2(WIDTH/SLICE).
- One sub-module, sub_slice_cla: combinational SLICE-bit lookahead add (x + y + cin -> s, cout). It is instantiated once and time-multiplexed by the FSM.

Test Plan:
- a=0x00000005, b=0x00000003, bin=0, start pulse -> done exactly 4 cycles later; diff=0x00000002, bout=0, ovf=0.
- a=0x00010000, b=0x00000001 -> diff=0x0000FFFF, bout=0 (borrow ripples across slices 0-1); with flags: neg=0.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, bout=1; flags: neg=1, zero=0. Then a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1.
- a=b=0x12345678: with bin=0 -> diff=0, bout=0, zero=1 (flags build); with bin=1 -> diff=0xFFFFFFFF, bout=1.
- Second start asserted 2 cycles after the first (busy=1) -> ignored; first result correct and only one done pulse. A start during the DONE cycle is accepted, giving back-to-back results.
- rst asserted asynchronously at RUN index 2 -> busy, done, diff and bout go to 0 immediately with no done pulse. A fresh start after rst release completes normally.
